gate_truth_checker: RTL and testbench

Self-checking stimulus/response stage for a 2-input logic gate. It sweeps the gate inputs A/B through all four combinations, waits a programmable settle time, samples the gate output Y, and compares it against an expected truth table. It sits directly upstream of the gate (drives A, B) and downstream of it (consumes Y). The default table targets the team's NOR gate.

---
 rtl/gate_check_pkg.sv | 22 ++
 rtl/gate_settle_timer.sv | 26 ++
 rtl/gate_truth_checker.sv | 113 +++++++++++
 tb/tb_gate_truth_checker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_check_pkg.sv
// rtl/gate_check_pkg.sv - shared FSM states, gate truth tables and helpers for the gate truth checker
package gate_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_SAMPLE,
    ST_FINISH
  } state_t;

  // Bit index of each table is {A,B}
  localparam logic [3:0] NOR_EXPECT  = 4'b0001;
  localparam logic [3:0] OR_EXPECT   = 4'b1110;
  localparam logic [3:0] AND_EXPECT  = 4'b1000;
  localparam logic [3:0] NAND_EXPECT = 4'b0111;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/gate_settle_timer.sv
// rtl/gate_settle_timer.sv - 4-bit loadable down-counter timing the settle wait
module gate_settle_timer (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero_next
);

  logic [3:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  // High when the current decrement brings the count to zero
  assign o_zero_next = (r_count <= 4'd1);

endmodule

// File: rtl/gate_truth_checker.sv
// rtl/gate_truth_checker.sv - sweeps A/B over a 2-input gate and checks Y against a truth table
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter logic [3:0] EXPECT = NOR_EXPECT,
  parameter int         SETTLE = 1,
  parameter int         PASSES = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_y,
  output logic       o_a,
  output logic       o_b,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [3:0] o_err_count,
  output logic [3:0] o_fail_vec
);

  localparam logic [3:0] SETTLE_V   = SETTLE[3:0];
  localparam logic [3:0] LAST_SWEEP = 4'(PASSES - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_idx;
  logic [3:0] r_sweep;
  logic [3:0] r_err;
  logic [3:0] r_fail;
  logic       r_pass;
  logic       r_a;
  logic       r_b;
  logic       w_hit;
  logic       w_last_vec;
  logic       w_timer_zero;
  logic [1:0] w_drive_idx;

  gate_settle_timer u_timer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (r_state == ST_DRIVE),
    .i_load_val  (SETTLE_V),
    .i_dec       (r_state == ST_WAIT),
    .o_zero_next (w_timer_zero)
  );

  assign w_last_vec  = (r_idx == 2'd3) && (r_sweep == LAST_SWEEP);
  assign w_drive_idx = (r_state == ST_SAMPLE) ? r_idx + 2'd1 : 2'd0;

  always_comb begin
    w_next_state = r_state;
    // Only an exact 0/1 match counts as a hit, so an unknown Y is a mismatch
    w_hit = 1'b0;
    if (i_y == EXPECT[r_idx]) w_hit = 1'b1;
    case (r_state)
      ST_IDLE:   if (i_start) w_next_state = ST_DRIVE;
      ST_DRIVE:  w_next_state = (SETTLE_V != 4'd0) ? ST_WAIT : ST_SAMPLE;
      ST_WAIT:   if (w_timer_zero) w_next_state = ST_SAMPLE;
      ST_SAMPLE: w_next_state = w_last_vec ? ST_FINISH : ST_DRIVE;
      ST_FINISH: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_idx   <= 2'd0;
      r_sweep <= 4'd0;
      r_err   <= 4'd0;
      r_fail  <= 4'd0;
      r_pass  <= 1'b0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == ST_IDLE) && i_start) begin
        r_idx   <= 2'd0;
        r_sweep <= 4'd0;
        r_err   <= 4'd0;
        r_fail  <= 4'd0;
        r_pass  <= 1'b0;
      end
      if (r_state == ST_SAMPLE) begin
        if (!w_hit) begin
          r_err         <= sat_inc4(r_err);
          r_fail[r_idx] <= 1'b1;
        end
        if (!w_last_vec) begin
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) r_sweep <= r_sweep + 4'd1;
        end
      end
      if (r_state == ST_FINISH) r_pass <= (r_err == 4'd0);
      // A/B only move on entry to DRIVE or IDLE, holding through WAIT and SAMPLE
      if (w_next_state == ST_DRIVE) begin
        {r_a, r_b} <= w_drive_idx;
      end else if (w_next_state == ST_IDLE) begin
        {r_a, r_b} <= 2'b00;
      end
    end
  end

  assign o_a         = r_a;
  assign o_b         = r_b;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_FINISH);
  assign o_pass      = r_pass;
  assign o_err_count = r_err;
  assign o_fail_vec  = r_fail;

endmodule

// File: tb/tb_gate_truth_checker.sv
// tb/tb_gate_truth_checker.sv - scoreboard bench: checker instances paired with a NOR gate model
module tb_gate_truth_checker;
  import gate_check_pkg::*;

  typedef struct {
    int         inst;
    int         cyc;
    logic       pass;
    logic [3:0] err;
    logic [3:0] fail;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start = 3'b000;
  int         mode = 0;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;

  exp_t q[$];
  exp_t pend [3];
  bit   pend_v [3];

  logic [2:0] a, b, y, busy, done, pass;
  logic [3:0] err [3];
  logic [3:0] fv [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate under test: NOR, or stuck-at-0 / stuck-at-1 faults selected by mode
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      y[i] = (mode == 0) ? ~(a[i] | b[i]) : ((mode == 1) ? 1'b0 : 1'b1);
    end
  end

  gate_truth_checker #(.EXPECT(NOR_EXPECT), .SETTLE(1), .PASSES(1)) u0 (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_y(y[0]),
    .o_a(a[0]), .o_b(b[0]), .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0]),
    .o_err_count(err[0]), .o_fail_vec(fv[0])
  );

  gate_truth_checker #(.EXPECT(NOR_EXPECT), .SETTLE(0), .PASSES(2)) u1 (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_y(y[1]),
    .o_a(a[1]), .o_b(b[1]), .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1]),
    .o_err_count(err[1]), .o_fail_vec(fv[1])
  );

  gate_truth_checker #(.EXPECT(NOR_EXPECT), .SETTLE(0), .PASSES(15)) u2 (
    .i_clk(clk), .i_rst(rst), .i_start(start[2]), .i_y(y[2]),
    .o_a(a[2]), .o_b(b[2]), .o_busy(busy[2]), .o_done(done[2]), .o_pass(pass[2]),
    .o_err_count(err[2]), .o_fail_vec(fv[2])
  );

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops an expectation on each DONE pulse; PASS is checked the cycle after
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (pend_v[i]) begin
        chk("pass_after_done", int'(pass[i]), int'(pend[i].pass));
        pend_v[i] = 1'b0;
      end
      if (done[i] === 1'b1) begin
        if ((q.size() == 0) || (q[0].inst != i)) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: instance %0d pulsed DONE at cycle %0d, expected no DONE", i, cyc);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("err_count", int'(err[i]), int'(e.err));
          chk("fail_vec", int'(fv[i]), int'(e.fail));
          pend[i]   = e;
          pend_v[i] = 1'b1;
        end
      end
    end
  end

  task automatic push_exp(input int inst, input int dcyc, input logic ep,
                          input logic [3:0] ee, input logic [3:0] ef);
    exp_t e;
    e.inst = inst;
    e.cyc  = dcyc;
    e.pass = ep;
    e.err  = ee;
    e.fail = ef;
    q.push_back(e);
  endtask

  // Called at a negedge; START is accepted at the next edge k = cyc+1
  task automatic launch(input int inst, input int settle, input int passes,
                        input logic ep, input logic [3:0] ee, input logic [3:0] ef);
    start[inst] = 1'b1;
    push_exp(inst, cyc + 1 + 4 * passes * (settle + 2), ep, ee, ef);
    @(negedge clk);
    start[inst] = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (((q.size() != 0) || pend_v[0] || pend_v[1] || pend_v[2]) && (n < limit)) begin
      @(negedge clk);
      n++;
    end
    if ((q.size() != 0) || pend_v[0] || pend_v[1] || pend_v[2]) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d DONE events outstanding after %0d cycles, expected 0", q.size(), limit);
      q.delete();
      for (int i = 0; i < 3; i++) pend_v[i] = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected the run to finish");
    $fatal(1);
  end

  initial begin
    int k;
    for (int i = 0; i < 3; i++) pend_v[i] = 1'b0;

    // Reset held, START raised while still in reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    start = 3'b111;
    @(negedge clk);
    chk("rst_a", int'(a[0]), 0);
    chk("rst_b", int'(b[0]), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass[0]), 0);
    chk("rst_err", int'(err[0]), 0);
    chk("rst_fail", int'(fv[0]), 0);
    start = 3'b000;
    rst   = 1'b0;
    @(negedge clk);
    chk("rst_no_start", int'(busy), 0);

    // Correct NOR, SETTLE=1, PASSES=1: each vector held 3 cycles, DONE at k+12
    mode = 0;
    k = cyc + 1;
    start[0] = 1'b1;
    push_exp(0, k + 12, 1'b1, 4'd0, 4'b0000);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) start[0] = 1'b0;
      chk("ab_vector", int'({a[0], b[0]}), c / 3);
    end
    wait_idle(20);

    // Stuck-at-0, SETTLE=0, PASSES=2: only index 0 fails, twice
    mode = 1;
    launch(1, 0, 2, 1'b0, 4'd2, 4'b0001);
    wait_idle(40);

    // Stuck-at-1, PASSES=15: 45 mismatches saturate the counter
    mode = 2;
    launch(2, 0, 15, 1'b0, 4'd15, 4'b1110);
    wait_idle(200);

    // START held high across two runs; first run faulty, second run clean
    mode = 1;
    k = cyc + 1;
    start[0] = 1'b1;
    push_exp(0, k + 12, 1'b0, 4'd1, 4'b0001);
    push_exp(0, k + 26, 1'b1, 4'd0, 4'b0000);
    for (int c = 0; c < 27; c++) begin
      @(negedge clk);
      if (c == 12) mode = 0;
      if (c == 13) chk("held_start_idle_gap", int'(busy[0]), 0);
      if (c == 14) begin
        chk("held_start_busy", int'(busy[0]), 1);
        chk("held_start_err_clr", int'(err[0]), 0);
        chk("held_start_fail_clr", int'(fv[0]), 0);
      end
      if (c == 26) start[0] = 1'b0;
    end
    wait_idle(10);

    // Reset during WAIT of vector 2 aborts the run without DONE
    mode = 1;
    start[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) start[0] = 1'b0;
    end
    chk("pre_rst_ab", int'({a[0], b[0]}), 2);
    chk("pre_rst_err", int'(err[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ab", int'({a[0], b[0]}), 0);
    chk("midrst_busy", int'(busy[0]), 0);
    chk("midrst_done", int'(done[0]), 0);
    chk("midrst_pass", int'(pass[0]), 0);
    chk("midrst_err", int'(err[0]), 0);
    chk("midrst_fail", int'(fv[0]), 0);
    repeat (4) @(negedge clk);
    chk("midrst_stays_idle", int'(busy[0]), 0);
    mode = 0;
    launch(0, 1, 1, 1'b1, 4'd0, 4'b0000);
    wait_idle(20);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
